// File: rtl/clk_period_monitor_pkg.sv
// clk_period_monitor_pkg: state encoding and default timing constants for the slow-clock period monitor
package clk_period_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } state_t;

    localparam int DEF_EXP_PERIOD = 100_000;
    localparam int DEF_TOL        = 100;
    localparam int DEF_TIMEOUT    = 200_000;

endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: three-flop synchroniser for an asynchronous input with a one-cycle rising-edge pulse
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sync;

    // shift the asynchronous input through the three-stage chain
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else        sync <= {sync[1:0], din};

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures the period of a slow divided clock in system-clock cycles and flags lock/loss
module clk_period_monitor
    import clk_period_monitor_pkg::*;
#(
    parameter  int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter  int TOL        = DEF_TOL,
    parameter  int TIMEOUT    = DEF_TIMEOUT,
    localparam int PW         = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          slow_clk,
    output logic [PW-1:0] period,
    output logic          period_valid,
    output logic          locked,
    output logic          timeout
);

    localparam logic [PW-1:0] LO   = PW'(EXP_PERIOD > TOL ? EXP_PERIOD - TOL : 0);
    localparam logic [PW-1:0] HI   = PW'(EXP_PERIOD + TOL);
    localparam logic [PW-1:0] TMAX = PW'(TIMEOUT);

    state_t        state;
    logic [PW-1:0] cnt;
    logic          rise;
    logic          in_tol;

    sync_rise_detect u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (slow_clk),
        .rise  (rise)
    );

    assign in_tol = (cnt >= LO) && (cnt <= HI);

    // measurement FSM: counts clk cycles between rises, saturating at TIMEOUT where the clock is declared lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE:
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= PW'(1);
                    end
                MEASURE:
                    if (rise) begin
                        period       <= cnt;
                        cnt          <= PW'(1);
                        period_valid <= 1'b1;
                        locked       <= in_tol;
                    end else if (cnt == TMAX) begin
                        state   <= LOST;
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                LOST:
                    if (rise) begin
                        state   <= MEASURE;
                        cnt     <= PW'(1);
                        timeout <= 1'b0;
                    end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb_clk_period_monitor: randomized and directed check of clk_period_monitor against an edge-timestamp model
module tb_clk_period_monitor;

    localparam int EXP = 20;
    localparam int TOL = 1;
    localparam int TMO = 40;
    localparam int PW  = $clog2(TMO + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          slow_clk = 1'b0;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          timeout;

    int n_chk = 0;
    int n_err = 0;

    int exp_period = 0;
    bit exp_valid = 0;
    bit exp_locked = 0;
    bit exp_timeout = 0;

    clk_period_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .slow_clk     (slow_clk),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Model: slow_clk is sampled at every clk edge; a 0->1 in the samples takes effect two edges
    // after the first high sample. Period = distance in edges between effective rises, unless the
    // gap exceeds TMO, in which case the clock is lost TMO edges after the last rise.
    initial begin
        bit hist[$];
        int k, last;
        bit have_ref, lost, act;
        int gap;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist = '{0, 0, 0};
                k = 0; last = 0; have_ref = 0; lost = 0;
                exp_period = 0; exp_valid = 0; exp_locked = 0; exp_timeout = 0;
            end else begin
                act = hist[hist.size()-2] & ~hist[hist.size()-3];
                exp_valid = 0;
                if (act) begin
                    if (have_ref && !lost) begin
                        gap = k - last;
                        exp_period = gap;
                        exp_valid = 1;
                        exp_locked = ((gap > EXP) ? gap - EXP : EXP - gap) <= TOL;
                    end
                    exp_timeout = 0;
                    lost = 0;
                    have_ref = 1;
                    last = k;
                end else if (have_ref && !lost && k - last == TMO) begin
                    lost = 1;
                    exp_timeout = 1;
                    exp_locked = 0;
                end
                hist.push_back(slow_clk);
                if (hist.size() > 4) void'(hist.pop_front());
                k++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("period", period, exp_period);
            chk("period_valid", period_valid, exp_valid);
            chk("locked", locked, exp_locked);
            chk("timeout", timeout, exp_timeout);
        end
    end

    task automatic run_period(input int p);
        for (int i = 0; i < p; i++) begin
            @(posedge clk); #2;
            slow_clk = (i < p / 2);
        end
    endtask

    task automatic lit(input string tag, input int p, input int l, input int t);
        #1;
        chk({tag, "_period"}, period, p);
        chk({tag, "_locked"}, locked, l);
        chk({tag, "_timeout"}, timeout, t);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        lit("reset", 0, 0, 0);
        chk("reset_valid", period_valid, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // nominal 20-cycle clock
        repeat (5) run_period(20);
        lit("nominal", 20, 1, 0);

        // tolerance edges
        run_period(19);
        run_period(21);
        lit("p19", 19, 1, 0);
        run_period(22);
        lit("p21", 21, 1, 0);
        run_period(20);
        lit("p22", 22, 0, 0);

        // loss and recovery
        run_period(20);
        run_period(20);
        run_period(60);
        lit("lost", 20, 0, 1);
        run_period(20);
        lit("resume1", 20, 0, 0);
        run_period(20);
        lit("resume2", 20, 1, 0);

        // period exactly at the timeout limit
        run_period(40);
        run_period(20);
        lit("p40", 40, 0, 0);

        // asynchronous reset mid-period
        run_period(20);
        run_period(20);
        repeat (7) begin @(posedge clk); #2; slow_clk = 1'b1; end
        @(posedge clk); #3;
        rst_n = 1'b0;
        slow_clk = 1'b0;
        #1;
        lit("async_rst", 0, 0, 0);
        chk("async_rst_valid", period_valid, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_period(20);
        lit("after_rst1", 0, 0, 0);
        run_period(20);
        lit("after_rst2", 20, 1, 0);

        // one long 80-cycle interval
        run_period(19);
        run_period(80);
        lit("long_gap", 19, 0, 1);
        run_period(20);
        lit("long_next1", 19, 0, 0);
        run_period(20);
        lit("long_next2", 20, 1, 0);

        // randomized periods, some beyond the timeout
        repeat (60) run_period($urandom_range(10, 50));
        repeat (5) run_period(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
